// File: rtl/cam_axis_tx.sv
// AXI4-Stream RGB to CameraLink base-configuration word transmitter with programmable blanking.
// Optional built-in test pattern source, enabled by defining CAM_TX_TEST_PATTERN_EN.
module cam_axis_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter int LINES      = 480,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 64,
  parameter int FV2LV      = 4,
  parameter int H_ACTIVE   = 640
) (
  input  logic                  cam_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
`ifdef CAM_TX_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  output logic [27:0]           cam_data_out,
  output logic                  underrun,
  output logic                  sof_err
);

  localparam int BMAX = (H_BLANK > V_BLANK) ? ((H_BLANK > FV2LV) ? H_BLANK : FV2LV)
                                            : ((V_BLANK > FV2LV) ? V_BLANK : FV2LV);
  localparam int CW = $clog2(BMAX + 1);
  localparam logic [CW-1:0] FV_LAST = CW'(FV2LV - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);
  localparam logic [15:0]   LN_LAST = 16'(LINES - 1);

  if (LINES < 1 || LINES > 65535 || H_BLANK < 1 || V_BLANK < 1 || FV2LV < 1 || H_ACTIVE < 1)
  begin : g_bad_cfg
    $error("cam_axis_tx: illegal timing parameter");
  end

  typedef enum logic [2:0] {S_IDLE, S_FV_LEAD, S_LINE, S_HBLANK, S_VBLANK} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [15:0]   r_line_cnt, w_line_nx;
  logic          r_first, w_first_nx;
  logic [27:0]   r_out;
  logic          r_underrun, r_sof_err;
  logic          w_ready, w_fv, w_lv, w_dv, w_eol, w_underrun, w_sof_err;
  logic [23:0]   w_pix;
`ifdef CAM_TX_TEST_PATTERN_EN
  localparam logic [15:0] PIX_LAST = 16'(H_ACTIVE - 1);
  logic          r_tp, w_tp_nx;
  logic [15:0]   r_pix_cnt, w_pix_nx;
`endif

  // Scatter ports A/B/C into the base-configuration bit order the receive parser expects.
  function automatic logic [27:0] cl_word(input logic fv, input logic lv, input logic dv,
                                          input logic [23:0] p);
    logic [27:0] w;
    w = '0;
    {w[5], w[27], w[6], w[4], w[3], w[2], w[1], w[0]}        = p[7:0];
    {w[11], w[10], w[14], w[13], w[12], w[9], w[8], w[7]}    = p[15:8];
    {w[17], w[16], w[22], w[21], w[20], w[19], w[18], w[15]} = p[23:16];
    w[26] = dv;
    w[25] = fv;
    w[24] = lv;
    return w;
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_line_nx  = r_line_cnt;
    w_first_nx = r_first;
    w_ready    = 1'b0;
    w_fv       = 1'b0;
    w_lv       = 1'b0;
    w_dv       = 1'b0;
    w_eol      = 1'b0;
    w_underrun = 1'b0;
    w_sof_err  = 1'b0;
    w_pix      = '0;
`ifdef CAM_TX_TEST_PATTERN_EN
    w_tp_nx    = r_tp;
    w_pix_nx   = r_pix_cnt;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef CAM_TX_TEST_PATTERN_EN
        if (test_pattern) begin
          w_tp_nx    = 1'b1;
          w_state_nx = S_FV_LEAD;
          w_cnt_nx   = '0;
        end else
`endif
        begin
          // Non-SOF beats are swallowed so the stream resynchronises on the next tuser.
          w_ready = ~s_axis_tuser[0];
          if (s_axis_tvalid & s_axis_tuser[0]) begin
            w_state_nx = S_FV_LEAD;
            w_cnt_nx   = '0;
          end
        end
      end
      S_FV_LEAD: begin
        w_fv = 1'b1;
        if (r_cnt == FV_LAST) begin
          w_state_nx = S_LINE;
          w_cnt_nx   = '0;
          w_line_nx  = '0;
          w_first_nx = 1'b1;
`ifdef CAM_TX_TEST_PATTERN_EN
          w_pix_nx   = '0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_LINE: begin
        w_fv = 1'b1;
        w_lv = 1'b1;
`ifdef CAM_TX_TEST_PATTERN_EN
        if (r_tp) begin
          w_dv     = 1'b1;
          w_pix    = {r_line_cnt[7:0], r_pix_cnt[7:0] ^ r_line_cnt[7:0], r_pix_cnt[7:0]};
          w_pix_nx = r_pix_cnt + 1'b1;
          if (r_pix_cnt == PIX_LAST) begin
            w_pix_nx = '0;
            w_eol    = 1'b1;
          end
        end else
`endif
        begin
          w_ready = ~(s_axis_tuser[0] & ~r_first);
          if (s_axis_tvalid & w_ready) begin
            w_dv       = 1'b1;
            w_pix      = s_axis_tdata[23:0];
            w_first_nx = 1'b0;
            w_eol      = s_axis_tlast;
          end else if (s_axis_tvalid) begin
            // Early SOF: truncate the frame and leave the beat for the next one.
            w_sof_err  = 1'b1;
            w_state_nx = S_VBLANK;
            w_cnt_nx   = '0;
          end else begin
            w_underrun = 1'b1;
          end
        end
        if (w_eol) begin
          w_cnt_nx = '0;
          if (r_line_cnt == LN_LAST) begin
            w_state_nx = S_VBLANK;
          end else begin
            w_line_nx  = r_line_cnt + 1'b1;
            w_state_nx = S_HBLANK;
          end
        end
      end
      S_HBLANK: begin
        w_fv = 1'b1;
        if (r_cnt == HB_LAST) begin
          w_state_nx = S_LINE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_VBLANK: begin
        if (r_cnt == VB_LAST) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
`ifdef CAM_TX_TEST_PATTERN_EN
          w_tp_nx    = 1'b0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge cam_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_line_cnt <= '0;
      r_first    <= 1'b0;
      r_out      <= '0;
      r_underrun <= 1'b0;
      r_sof_err  <= 1'b0;
`ifdef CAM_TX_TEST_PATTERN_EN
      r_tp       <= 1'b0;
      r_pix_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_line_cnt <= w_line_nx;
      r_first    <= w_first_nx;
      r_out      <= cl_word(w_fv, w_lv, w_dv, w_pix);
      r_underrun <= w_underrun;
      r_sof_err  <= w_sof_err;
`ifdef CAM_TX_TEST_PATTERN_EN
      r_tp       <= w_tp_nx;
      r_pix_cnt  <= w_pix_nx;
`endif
    end
  end

  // Gated with rst so the handshake drops the instant reset is asserted.
  assign s_axis_tready = w_ready & ~rst;
  assign cam_data_out  = r_out;
  assign underrun      = r_underrun;
  assign sof_err       = r_sof_err;

endmodule

// File: tb/tb_cam_axis_tx.sv
// Table-driven bench for cam_axis_tx: per-cycle input/expected-output rows checked through a scoreboard,
// followed by a hand-written asynchronous reset sequence.
module tb_cam_axis_tx;
  localparam int LINES = 2, HB = 3, VB = 5, FVL = 2, HA = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0;
  logic [0:0]  tuser = '0;
  logic        tready, ur, se;
  logic [27:0] cam;
`ifdef CAM_TX_TEST_PATTERN_EN
  logic        tp = 1'b0;
`endif

  always #5 clk = ~clk;

  cam_axis_tx #(
    .DATA_WIDTH(24), .USER_WIDTH(1), .LINES(LINES), .H_BLANK(HB),
    .V_BLANK(VB), .FV2LV(FVL), .H_ACTIVE(HA)
  ) dut (
    .cam_clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
`ifdef CAM_TX_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .cam_data_out(cam), .underrun(ur), .sof_err(se)
  );

  typedef struct {
    logic v, u, l, t;
    logic [23:0] d;
    logic [27:0] w;
    logic ur, se, rdy;
  } vec_t;
  typedef struct {
    logic [27:0] w;
    logic ur, se;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output word built from the documented port-to-bit placement table.
  function automatic logic [27:0] enc(input logic fv, input logic lv, input logic dv,
                                      input logic [23:0] p);
    int pos [24];
    logic [27:0] w;
    pos = '{0, 1, 2, 3, 4, 6, 27, 5, 7, 8, 9, 12, 13, 14, 10, 11,
            15, 18, 19, 20, 21, 22, 16, 17};
    w = '0;
    for (int i = 0; i < 24; i++) if (p[i]) w[pos[i]] = 1'b1;
    w[26] = dv;
    w[25] = fv;
    w[24] = lv;
    return w;
  endfunction

  function automatic logic [23:0] P(input int i);
    return {8'(3 * i + 3), 8'(3 * i + 2), 8'(3 * i + 1)};
  endfunction

  task automatic row(input logic v, input logic u, input logic l, input logic t,
                     input logic [23:0] d, input logic fv, input logic lv, input logic dv,
                     input logic [23:0] p, input logic ur_e, input logic se_e, input logic rdy_e);
    vec_t r;
    r.v = v; r.u = u; r.l = l; r.t = t; r.d = d;
    r.w = enc(fv, lv, dv, p);
    r.ur = ur_e; r.se = se_e; r.rdy = rdy_e;
    vecs.push_back(r);
  endtask

  task automatic sof_lead(input logic [23:0] d);
    row(1, 1, 0, 0, d, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < FVL; i++) row(1, 1, 0, 0, d, 1, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic px(input logic [23:0] d, input logic u, input logic l);
    row(1, u, l, 0, d, 1, 1, 1, d, 0, 0, 1);
  endtask

  task automatic hblank();
    for (int i = 0; i < HB; i++) row(0, 0, 0, 0, '0, 1, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic vblank_idle();
    for (int i = 0; i < VB; i++) row(0, 0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 0);
    row(0, 0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(cam), 0);
    chk("rst_underrun", 32'(ur), 0);
    chk("rst_sof_err", 32'(se), 0);
    chk("rst_tready", 32'(tready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_tready", 32'(tready), 1);

    // Basic frame: two continuous 4-pixel lines
    sof_lead(P(0));
    px(P(0), 1, 0); px(P(1), 0, 0); px(P(2), 0, 0); px(P(3), 0, 1);
    hblank();
    px(P(4), 0, 0); px(P(5), 0, 0); px(P(6), 0, 0); px(P(7), 0, 1);
    vblank_idle();

    // Mid-line stall of two cycles
    sof_lead(P(10));
    px(P(10), 1, 0);
    repeat (2) row(0, 0, 0, 0, '0, 1, 1, 0, '0, 1, 0, 1);
    px(P(11), 0, 0); px(P(12), 0, 0); px(P(13), 0, 1);
    hblank();
    px(P(14), 0, 0); px(P(15), 0, 0); px(P(16), 0, 0); px(P(17), 0, 1);
    vblank_idle();

    // Resync beats dropped in idle, then a frame truncated by an early SOF
    for (int i = 0; i < 3; i++) row(1, 0, 0, 0, P(20 + i), 0, 0, 0, '0, 0, 0, 1);
    sof_lead(P(30));
    px(P(30), 1, 0); px(P(31), 0, 0); px(P(32), 0, 0); px(P(33), 0, 1);
    hblank();
    px(P(34), 0, 0); px(P(35), 0, 0);
    row(1, 1, 0, 0, P(36), 1, 1, 0, '0, 0, 1, 0);
    for (int i = 0; i < VB; i++) row(1, 1, 0, 0, P(36), 0, 0, 0, '0, 0, 0, 0);
    sof_lead(P(36));
    px(P(36), 1, 0); px(P(37), 0, 0); px(P(38), 0, 0); px(P(39), 0, 1);
    hblank();
    px(P(40), 0, 0); px(P(41), 0, 0); px(P(42), 0, 0); px(P(43), 0, 1);
    vblank_idle();

    // One-pixel line: tlast on the SOF beat
    sof_lead(P(60));
    px(P(60), 1, 1);
    hblank();
    px(P(61), 0, 0); px(P(62), 0, 1);
    vblank_idle();

`ifdef CAM_TX_TEST_PATTERN_EN
    // Internal pattern with AXIS beats offered but never accepted
    row(0, 0, 0, 1, '0, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < FVL; i++) row(1, 0, 0, 0, P(0), 1, 0, 0, '0, 0, 0, 0);
    for (int ln = 0; ln < LINES; ln++) begin
      for (int i = 0; i < HA; i++)
        row(1, 0, 0, 0, P(0), 1, 1, 1, {8'(ln), 8'(i) ^ 8'(ln), 8'(i)}, 0, 0, 0);
      if (ln < LINES - 1) hblank();
    end
    vblank_idle();
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      tvalid = vecs[i].v; tuser = vecs[i].u; tlast = vecs[i].l; tdata = vecs[i].d;
`ifdef CAM_TX_TEST_PATTERN_EN
      tp = vecs[i].t;
`endif
      #1 chk($sformatf("tready[%0d]", i), 32'(tready), 32'(vecs[i].rdy));
      e.w = vecs[i].w; e.ur = vecs[i].ur; e.se = vecs[i].se;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("word[%0d]", i), 32'(cam), 32'(e.w));
      chk($sformatf("underrun[%0d]", i), 32'(ur), 32'(e.ur));
      chk($sformatf("sof_err[%0d]", i), 32'(se), 32'(e.se));
    end

    // Asynchronous reset while a line is being sent
    @(negedge clk);
    tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0; tdata = P(70);
    repeat (2 + FVL) @(posedge clk);
    #1 chk("pre_rst_pixel", 32'(cam), 32'(enc(1, 1, 1, P(70))));
    @(negedge clk);
    tuser = 1'b0; tdata = P(71);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_word", 32'(cam), 0);
    chk("async_rst_tready", 32'(tready), 0);
    @(posedge clk);
    #1 chk("rst_hold_word", 32'(cam), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_resync_tready", 32'(tready), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("post_rst_idle[%0d]", i), 32'(cam), 0);
    end
    @(negedge clk);
    tuser = 1'b1;
    #1 chk("post_rst_sof_tready", 32'(tready), 0);
    @(posedge clk);
    #1 chk("post_rst_sof_idle", 32'(cam), 0);
    @(posedge clk);
    #1 chk("post_rst_fval", 32'(cam), 32'(enc(1, 0, 0, '0)));
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
